// File: rtl/oversampled_deserializer.sv
// rtl/oversampled_deserializer.sv - oversampled framed serial receiver with word FIFO
// Recovers start/data/parity/stop frames from an async line and buffers good words.
module oversampled_deserializer #(
  parameter int PKT_W      = 8,
  parameter int OVERSAMPLE = 16,
  parameter int MSB_FIRST  = 1,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                io_sIn,
  input  logic                                io_rdEn,
  output logic                                io_dataReady,
  output logic [PKT_W-1:0]                    io_pOut,
  output logic                                io_validOut,
  output logic                                io_frameErr,
  output logic                                io_parityErr,
  output logic                                io_overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     io_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(PKT_W + 1);
  localparam logic [OW-1:0] HALF_M1  = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] FULL_M1  = OW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(PKT_W - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic          ODD      = (PARITY == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BREAK} state_t;

  state_t          state, next_state;
  logic [1:0]      sync;
  logic [1:0]      primed;
  logic            armed;
  logic            line;
  logic [OW-1:0]   os_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [PKT_W-1:0] word, word_next;
  logic [PKT_W:0]  ext_msb, ext_lsb;
  logic            par_acc, par_bad;
  logic            mid;
  logic            push, frame_err_c, parity_err_c;

  logic [PKT_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, pop, push_ok;

  assign line = sync[1];

  // Sync flops reset high; primed tracks when they hold real line samples, so
  // arming after reset needs a genuine high from the line.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync   <= 2'b11;
      primed <= 2'b00;
      armed  <= 1'b0;
    end else begin
      sync   <= {sync[0], io_sIn};
      primed <= {primed[0], 1'b1};
      if (primed[1] && line) armed <= 1'b1;
    end
  end

  assign mid = (state == START) ? (os_cnt == HALF_M1) : (os_cnt == FULL_M1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (armed && !line) next_state = START;
      START:   if (mid) next_state = line ? IDLE : DATA;
      DATA:    if (mid && bit_cnt == LAST_BIT) next_state = (PARITY != 0) ? PAR : STOP;
      PAR:     if (mid) next_state = STOP;
      STOP:    if (mid) next_state = line ? IDLE : BREAK;
      BREAK:   if (line) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    push         = (state == STOP) && mid && line && !par_bad;
    parity_err_c = (state == STOP) && mid && line && par_bad;
    frame_err_c  = (state == STOP) && mid && !line;
  end

  always_comb begin
    ext_msb   = {word, line};
    ext_lsb   = {line, word};
    word_next = (MSB_FIRST != 0) ? ext_msb[PKT_W-1:0] : ext_lsb[PKT_W:1];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      os_cnt  <= '0;
      bit_cnt <= '0;
      word    <= '0;
      par_acc <= 1'b0;
      par_bad <= 1'b0;
    end else begin
      if (state == IDLE || state == BREAK || mid) os_cnt <= '0;
      else                                        os_cnt <= os_cnt + 1'b1;
      if (state == IDLE) begin
        bit_cnt <= '0;
        par_acc <= 1'b0;
        par_bad <= 1'b0;
      end else if (state == DATA && mid) begin
        bit_cnt <= bit_cnt + 1'b1;
        word    <= word_next;
        par_acc <= par_acc ^ line;
      end else if (state == PAR && mid) begin
        par_bad <= par_acc ^ line ^ ODD;
      end
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign full    = (count == FULL_CNT);
  assign pop     = io_rdEn && (count != '0);
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      io_pOut      <= '0;
      io_validOut  <= 1'b0;
      io_frameErr  <= 1'b0;
      io_parityErr <= 1'b0;
      io_overflow  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        io_pOut <= mem[rd_ptr];
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      io_validOut  <= pop;
      io_frameErr  <= frame_err_c;
      io_parityErr <= parity_err_c;
      io_overflow  <= push && full && !pop;
    end
  end

  assign io_dataReady = (count != '0);
  assign io_count     = count;

endmodule

// File: tb/tb_oversampled_deserializer.sv
// tb/tb_oversampled_deserializer.sv - self-checking bench for oversampled_deserializer
// Three instances (MSB-first, LSB-first, even parity) share one clock and reset.
module tb_oversampled_deserializer;
  localparam int OS = 16;
  localparam int N  = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n;
  logic       s_in [N];
  logic       rd_en [N];
  logic       ready [N];
  logic [7:0] p_out [N];
  logic       valid [N];
  logic       ferr [N];
  logic       perr [N];
  logic       ovf [N];
  logic [2:0] cnt [N];

  int msb_cfg [N] = '{1, 0, 1};
  int par_cfg [N] = '{0, 0, 1};

  oversampled_deserializer #(.PKT_W(8), .OVERSAMPLE(OS), .MSB_FIRST(1), .PARITY(0), .FIFO_DEPTH(4)) u0 (
    .clock(clock), .reset_n(reset_n), .io_sIn(s_in[0]), .io_rdEn(rd_en[0]),
    .io_dataReady(ready[0]), .io_pOut(p_out[0]), .io_validOut(valid[0]), .io_frameErr(ferr[0]),
    .io_parityErr(perr[0]), .io_overflow(ovf[0]), .io_count(cnt[0]));
  oversampled_deserializer #(.PKT_W(8), .OVERSAMPLE(OS), .MSB_FIRST(0), .PARITY(0), .FIFO_DEPTH(4)) u1 (
    .clock(clock), .reset_n(reset_n), .io_sIn(s_in[1]), .io_rdEn(rd_en[1]),
    .io_dataReady(ready[1]), .io_pOut(p_out[1]), .io_validOut(valid[1]), .io_frameErr(ferr[1]),
    .io_parityErr(perr[1]), .io_overflow(ovf[1]), .io_count(cnt[1]));
  oversampled_deserializer #(.PKT_W(8), .OVERSAMPLE(OS), .MSB_FIRST(1), .PARITY(1), .FIFO_DEPTH(4)) u2 (
    .clock(clock), .reset_n(reset_n), .io_sIn(s_in[2]), .io_rdEn(rd_en[2]),
    .io_dataReady(ready[2]), .io_pOut(p_out[2]), .io_validOut(valid[2]), .io_frameErr(ferr[2]),
    .io_parityErr(perr[2]), .io_overflow(ovf[2]), .io_count(cnt[2]));

  int checks = 0;
  int failures = 0;

  // Observed pulse tallies, sampled mid-cycle.
  int n_ferr [N];
  int n_perr [N];
  int n_ovf [N];
  always @(negedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (ferr[i] === 1'b1) n_ferr[i]++;
      if (perr[i] === 1'b1) n_perr[i]++;
      if (ovf[i] === 1'b1)  n_ovf[i]++;
    end
  end

  // Reference model: head of the list is m_fifo[i][0].
  logic [7:0] m_fifo [N][4];
  int m_cnt [N];
  int e_ferr [N];
  int e_perr [N];
  int e_ovf [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_bit(input int i, input logic v, input int nbits);
    s_in[i] = v;
    cyc(nbits * OS);
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = b[7-k];
    return r;
  endfunction

  function automatic logic good_par(input int i, input logic [7:0] w);
    return (par_cfg[i] == 1) ? ^w : ~^w;
  endfunction

  task automatic model_frame(input int i, input logic [7:0] b, input logic par_bit, input logic stop_bit);
    logic [7:0] w;
    int ones;
    logic par_ok;
    w = (msb_cfg[i] != 0) ? b : rev8(b);
    ones = $countones(w) + int'(par_bit);
    par_ok = (par_cfg[i] == 0) || ((par_cfg[i] == 1) ? (ones % 2 == 0) : (ones % 2 == 1));
    if (!stop_bit)        e_ferr[i]++;
    else if (!par_ok)     e_perr[i]++;
    else if (m_cnt[i] == 4) e_ovf[i]++;
    else begin
      m_fifo[i][m_cnt[i]] = w;
      m_cnt[i]++;
    end
  endtask

  // b holds the data bits in line order, b[7] transmitted first.
  task automatic send(input int i, input logic [7:0] b, input logic par_bit, input logic stop_bit);
    drive_bit(i, 1'b0, 1);
    for (int k = 7; k >= 0; k--) drive_bit(i, b[k], 1);
    if (par_cfg[i] != 0) drive_bit(i, par_bit, 1);
    if (stop_bit) drive_bit(i, 1'b1, 1);
    else begin
      drive_bit(i, 1'b0, 3);
      drive_bit(i, 1'b1, 2);
    end
    model_frame(i, b, par_bit, stop_bit);
  endtask

  task automatic send_word(input int i, input logic [7:0] w);
    send(i, (msb_cfg[i] != 0) ? w : rev8(w), (par_cfg[i] != 0) ? good_par(i, w) : 1'b0, 1'b1);
  endtask

  task automatic read_check(input int i);
    logic had;
    logic [7:0] head;
    had = (m_cnt[i] > 0);
    head = m_fifo[i][0];
    rd_en[i] = 1'b1;
    cyc(1);
    rd_en[i] = 1'b0;
    if (had) begin
      for (int k = 0; k < 3; k++) m_fifo[i][k] = m_fifo[i][k+1];
      m_cnt[i]--;
    end
    check($sformatf("valid_pulse%0d", i), valid[i], had);
    if (had) check($sformatf("pop_data%0d", i), p_out[i], head);
    check($sformatf("count_after_pop%0d", i), cnt[i], m_cnt[i]);
    cyc(1);
    check($sformatf("valid_low%0d", i), valid[i], 1'b0);
    if (had) check($sformatf("pout_hold%0d", i), p_out[i], head);
  endtask

  task automatic check_counts(input int i);
    check($sformatf("count%0d", i), cnt[i], m_cnt[i]);
    check($sformatf("ready%0d", i), ready[i], m_cnt[i] > 0);
    check($sformatf("frame_errs%0d", i), n_ferr[i], e_ferr[i]);
    check($sformatf("parity_errs%0d", i), n_perr[i], e_perr[i]);
    check($sformatf("overflows%0d", i), n_ovf[i], e_ovf[i]);
  endtask

  task automatic check_reset_outputs(input int i);
    check($sformatf("rst_ready%0d", i), ready[i], 1'b0);
    check($sformatf("rst_count%0d", i), cnt[i], 3'd0);
    check($sformatf("rst_pout%0d", i), p_out[i], 8'h00);
    check($sformatf("rst_valid%0d", i), valid[i], 1'b0);
    check($sformatf("rst_ferr%0d", i), ferr[i], 1'b0);
    check($sformatf("rst_perr%0d", i), perr[i], 1'b0);
    check($sformatf("rst_ovf%0d", i), ovf[i], 1'b0);
  endtask

  initial begin
    logic [7:0] w;
    int i;
    logic bad_par;
    logic stop_b;
    for (int k = 0; k < N; k++) begin
      s_in[k] = 1'b1;
      rd_en[k] = 1'b0;
    end
    reset_n = 1'b0;
    cyc(3);
    for (int k = 0; k < N; k++) check_reset_outputs(k);
    reset_n = 1'b1;
    cyc(2 * OS);

    // Basic MSB-first word
    send_word(0, 8'hA5);
    cyc(3);
    check("a5_ready", ready[0], 1'b1);
    check("a5_count", cnt[0], 3'd1);
    read_check(0);
    check("a5_value", p_out[0], 8'hA5);
    check("a5_empty", ready[0], 1'b0);

    // Same line pattern, opposite bit orders
    send(1, 8'b1000_0000, 1'b0, 1'b1);
    send(0, 8'b1000_0000, 1'b0, 1'b1);
    cyc(3);
    read_check(1);
    check("lsb_first_value", p_out[1], 8'h01);
    read_check(0);
    check("msb_first_value", p_out[0], 8'h80);

    // Even parity: bad then good
    send(2, 8'h07, 1'b0, 1'b1);
    cyc(3);
    check_counts(2);
    send(2, 8'h07, 1'b1, 1'b1);
    cyc(3);
    check_counts(2);
    read_check(2);
    check("par_good_value", p_out[2], 8'h07);

    // Framing error then recovery
    send(0, 8'h3C, 1'b0, 1'b0);
    check_counts(0);
    send_word(0, 8'h3C);
    cyc(3);
    read_check(0);
    check("after_break_value", p_out[0], 8'h3C);

    // Overflow on the fifth back-to-back word
    send_word(0, 8'h11);
    send_word(0, 8'h22);
    send_word(0, 8'h33);
    send_word(0, 8'h44);
    send_word(0, 8'h55);
    cyc(3);
    check_counts(0);
    check("ovf_full_count", cnt[0], 3'd4);
    for (int k = 0; k < 4; k++) read_check(0);
    check("ovf_last_value", p_out[0], 8'h44);
    check("ovf_drained", ready[0], 1'b0);
    read_check(0);

    // Short glitch is ignored, receiver still works
    s_in[0] = 1'b0;
    cyc(OS / 4);
    s_in[0] = 1'b1;
    cyc(2 * OS);
    check_counts(0);
    send_word(0, 8'hC3);
    cyc(3);
    read_check(0);

    // Reset in the middle of a data field
    drive_bit(0, 1'b0, 1);
    drive_bit(0, 1'b1, 1);
    drive_bit(0, 1'b0, 2);
    reset_n = 1'b0;
    cyc(2);
    check_reset_outputs(0);
    s_in[0] = 1'b1;
    reset_n = 1'b1;
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
    cyc(3 * OS);
    check_counts(0);
    send_word(0, 8'h5A);
    cyc(3);
    read_check(0);
    check("post_reset_value", p_out[0], 8'h5A);

    // Randomized frames against the model
    repeat (14) begin
      i = $urandom_range(0, N - 1);
      w = 8'($urandom);
      bad_par = (par_cfg[i] != 0) && ($urandom_range(0, 3) == 0);
      stop_b = ($urandom_range(0, 4) != 0);
      send(i, (msb_cfg[i] != 0) ? w : rev8(w),
           ((par_cfg[i] != 0) ? good_par(i, w) : 1'b0) ^ bad_par, stop_b);
    end
    cyc(3);
    for (int k = 0; k < N; k++) begin
      check_counts(k);
      while (m_cnt[k] > 0) read_check(k);
      read_check(k);
      check_counts(k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
